// File: rtl/fifo_push_arb.sv
// Round-robin push arbiter, occupancy counter and producer-tag tracker for one single-clock FIFO.
// Optional per-producer quota gating is built when FIFO_PUSH_ARB_QUOTA_EN is defined.
module fifo_push_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int SIZE  = 32,
    parameter int QUOTA = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           gnt,
    output logic                      fifo_push,
    output logic [WIDTH-1:0]          fifo_wdata,
    input  logic                      pop,
    output logic                      fifo_pop,
    output logic                      rvalid,
    output logic [$clog2(NREQ)-1:0]   rtag,
    output logic [$clog2(SIZE):0]     occupancy,
    output logic                      full,
    output logic                      empty
);

    localparam int TW = $clog2(NREQ);
    localparam int AW = $clog2(SIZE);
    localparam int PW = AW + 1;

    if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
        $error("fifo_push_arb: NREQ must be in 2..16");
    end
    if (SIZE < 4 || (SIZE & (SIZE - 1)) != 0) begin : g_bad_size
        $error("fifo_push_arb: SIZE must be a power of two, at least 4");
    end
    if (QUOTA < 1 || QUOTA > SIZE) begin : g_bad_quota
        $error("fifo_push_arb: QUOTA must be in 1..SIZE");
    end

    logic [TW-1:0] rr_reg, rr_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] occ_reg, occ_next;
    logic          rvalid_reg, rvalid_next;
    logic [TW-1:0] rtag_reg, rtag_next;

    logic [TW-1:0] tag_mem [SIZE];

    logic            full_int;
    logic            empty_int;
    logic [NREQ-1:0] elig;
    logic [TW-1:0]   rot_idx [NREQ];
    logic [NREQ-1:0] rot_elig;
    logic            grant_raw;
    logic            grant_any;
    logic [TW-1:0]   gnt_idx;
    logic [TW-1:0]   pop_tag;
    logic            pop_ok;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign full_int  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty_int = (wr_ptr_reg == rd_ptr_reg);

    assign pop_ok  = pop && !empty_int && !rst;
    assign pop_tag = tag_mem[rd_ptr_reg[AW-1:0]];

    // Eligibility uses registered state only; a same-cycle pop frees nothing yet.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_elig
`ifdef FIFO_PUSH_ARB_QUOTA_EN
        logic [PW-1:0] cnt_reg, cnt_next;
        logic          inc, dec;

        assign inc = grant_any && (gnt_idx == TW'(gi));
        assign dec = pop_ok && (pop_tag == TW'(gi));

        always_comb begin
            cnt_next = cnt_reg;
            case ({inc, dec})
                2'b10:   cnt_next = cnt_reg + 1'b1;
                2'b01:   cnt_next = cnt_reg - 1'b1;
                default: cnt_next = cnt_reg;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_next;
            end
        end

        assign elig[gi] = req[gi] && !full_int && (cnt_reg < PW'(QUOTA));
`else
        assign elig[gi] = req[gi] && !full_int;
`endif
    end

    // Candidate order starts at rr and wraps modulo NREQ.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
        assign rot_idx[gi]  = TW'((32'(rr_reg) + 32'(gi)) % 32'(NREQ));
        assign rot_elig[gi] = elig[rot_idx[gi]];
    end

    always_comb begin
        grant_raw = 1'b0;
        gnt_idx   = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot_elig[j]) begin
                grant_raw = 1'b1;
                gnt_idx   = rot_idx[j];
            end
        end
    end

    assign grant_any = grant_raw && !rst;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
        assign gnt[gi] = grant_any && (gnt_idx == TW'(gi));
    end

    always_comb begin
        fifo_wdata = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (gnt[j]) begin
                fifo_wdata = req_data[j*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        rr_next = rr_reg;
        if (grant_any) begin
            rr_next = (gnt_idx == TW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg + PW'(grant_any);
        rd_ptr_next = rd_ptr_reg + PW'(pop_ok);
        case ({grant_any, pop_ok})
            2'b10:   occ_next = occ_reg + 1'b1;
            2'b01:   occ_next = occ_reg - 1'b1;
            default: occ_next = occ_reg;
        endcase
        rvalid_next = pop_ok;
        rtag_next   = pop_ok ? pop_tag : rtag_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_reg     <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
            rvalid_reg <= 1'b0;
            rtag_reg   <= '0;
        end else begin
            rr_reg     <= rr_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            occ_reg    <= occ_next;
            rvalid_reg <= rvalid_next;
            rtag_reg   <= rtag_next;
        end
    end

    // Tag contents need no reset: the pointers decide what is live.
    always_ff @(posedge clk) begin
        if (grant_any) begin
            tag_mem[wr_ptr_reg[AW-1:0]] <= gnt_idx;
        end
    end

    assign fifo_push = grant_any;
    assign fifo_pop  = pop_ok;
    assign rvalid    = rvalid_reg;
    assign rtag      = rtag_reg;
    assign occupancy = occ_reg;
    assign full      = full_int;
    assign empty     = empty_int;

endmodule

// File: tb/tb_fifo_push_arb.sv
// Directed bench for fifo_push_arb: reference model plus tag scoreboard, checked every cycle.
module tb_fifo_push_arb;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int SIZE  = 32;
    localparam int QUOTA = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic                  pop = 1'b0;
    logic [NREQ-1:0]       gnt;
    logic                  fifo_push;
    logic [WIDTH-1:0]      fifo_wdata;
    logic                  fifo_pop;
    logic                  rvalid;
    logic [1:0]            rtag;
    logic [5:0]            occupancy;
    logic                  full;
    logic                  empty;

    fifo_push_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .SIZE(SIZE), .QUOTA(QUOTA)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .fifo_push(fifo_push), .fifo_wdata(fifo_wdata), .pop(pop), .fifo_pop(fifo_pop),
        .rvalid(rvalid), .rtag(rtag), .occupancy(occupancy), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int m_rr;
    int m_occ;
    int m_cnt [NREQ];
    int m_rtag;
    bit exp_rvalid;
    int sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_rr = 0;
        m_occ = 0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        m_rtag = 0;
        exp_rvalid = 1'b0;
        sb.delete();
    endtask

    // One clock: drive at negedge, check combinational outputs, advance model, check registers after posedge.
    task automatic step(input logic [NREQ-1:0] r, input logic p);
        int   k;
        bit   found;
        bit   exp_pop;
        logic [NREQ-1:0] exp_gnt;
        @(negedge clk);
        req = r;
        pop = p;
        for (int j = 0; j < NREQ; j++) req_data[j*WIDTH +: WIDTH] = WIDTH'($urandom);
        #1;
        found = 1'b0;
        k = 0;
        for (int j = 0; j < NREQ; j++) begin
            int c;
            c = (m_rr + j) % NREQ;
`ifdef FIFO_PUSH_ARB_QUOTA_EN
            if (!found && r[c] && m_occ < SIZE && m_cnt[c] < QUOTA) begin
`else
            if (!found && r[c] && m_occ < SIZE) begin
`endif
                found = 1'b1;
                k = c;
            end
        end
        exp_gnt = '0;
        if (found) exp_gnt[k] = 1'b1;
        exp_pop = p && (m_occ != 0);
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("fifo_push", 32'(fifo_push), 32'(found));
        check("fifo_wdata", 32'(fifo_wdata), found ? 32'(req_data[k*WIDTH +: WIDTH]) : 32'd0);
        check("fifo_pop", 32'(fifo_pop), 32'(exp_pop));
        exp_rvalid = exp_pop;
        if (exp_pop) begin
            m_rtag = sb.pop_front();
            m_cnt[m_rtag]--;
            m_occ--;
        end
        if (found) begin
            sb.push_back(k);
            m_cnt[k]++;
            m_rr = (k + 1) % NREQ;
            m_occ++;
            $display("push prod=%0d data=%04h", k, req_data[k*WIDTH +: WIDTH]);
        end
        @(posedge clk);
        #1;
        check("rvalid", 32'(rvalid), 32'(exp_rvalid));
        check("rtag", 32'(rtag), 32'(m_rtag));
        check("occupancy", 32'(occupancy), 32'(m_occ));
        check("full", 32'(full), 32'(m_occ == SIZE));
        check("empty", 32'(empty), 32'(m_occ == 0));
        if (rvalid) $display("pop  tag=%0d occ=%0d", rtag, occupancy);
    endtask

    task automatic drain();
        for (int i = 0; i < SIZE + 2 && m_occ > 0; i++) step('0, 1'b1);
        check("drained", 32'(empty), 32'd1);
    endtask

    int exp_tags [3] = '{3, 1, 0};

    initial begin
        // Reset held for 3 cycles with all requests and pop asserted.
        rst = 1'b1;
        req = 4'hF;
        pop = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_fifo_push", 32'(fifo_push), 32'd0);
        check("rst_fifo_wdata", 32'(fifo_wdata), 32'd0);
        check("rst_fifo_pop", 32'(fifo_pop), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rtag", 32'(rtag), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        rst = 1'b0;
        req = '0;
        pop = 1'b0;
        reset_model();

        // Fairness: all producers requesting fill the FIFO in strict rotation.
        for (int i = 0; i < SIZE; i++) begin
            step(4'hF, 1'b0);
            check("fair_gnt_seq", 32'(sb[sb.size()-1]), 32'(i % NREQ));
        end
        check("fair_full", 32'(full), 32'd1);
        check("fair_occ", 32'(occupancy), 32'd32);
        step(4'hF, 1'b0);
        check("fair_full_gnt", 32'(gnt), 32'd0);

        // Full boundary: same-cycle pop does not allow a push.
        step(4'hF, 1'b1);
        check("fb_occ31", 32'(occupancy), 32'd31);
        check("fb_first_tag", 32'(rtag), 32'd0);
        step(4'hF, 1'b0);
        check("fb_occ32", 32'(occupancy), 32'd32);
        drain();

        // Empty pop is ignored.
        step('0, 1'b1);
        check("empty_pop_rvalid", 32'(rvalid), 32'd0);
        check("empty_pop_occ", 32'(occupancy), 32'd0);

        // Single producer: quota limits it, otherwise it fills the FIFO.
        for (int i = 0; i < SIZE + 2; i++) step(4'b0001, 1'b0);
`ifdef FIFO_PUSH_ARB_QUOTA_EN
        check("quota_occ", 32'(occupancy), 32'(QUOTA));
`else
        check("quota_occ", 32'(occupancy), 32'(SIZE));
`endif
        step(4'b0001, 1'b1);
        step(4'b0001, 1'b0);
        check("quota_regrant", 32'(sb[sb.size()-1]), 32'd0);
        drain();

        // Tag order: producers 3, 1, 0 then three pops.
        step(4'b1000, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0001, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step('0, 1'b1);
            check("tag_order_rvalid", 32'(rvalid), 32'd1);
            check("tag_order", 32'(rtag), 32'(exp_tags[i]));
        end
        step('0, 1'b0);
        check("tag_order_done", 32'(rvalid), 32'd0);

        // Pointer wrap: 100 overlapping push/pop pairs.
        step(4'(($urandom_range(1, 15))), 1'b0);
        for (int i = 0; i < 100; i++) begin
            step(4'($urandom_range(1, 15)), 1'b1);
            check("occ_bound", 32'(occupancy <= 6'd32), 32'd1);
        end
        drain();

        // Asynchronous reset while a pop result is valid.
        step(4'hF, 1'b0);
        step(4'hF, 1'b0);
        step('0, 1'b1);
        check("pre_arst_rvalid", 32'(rvalid), 32'd1);
        #1;
        rst = 1'b1;
        req = 4'hF;
        #1;
        check("arst_rvalid", 32'(rvalid), 32'd0);
        check("arst_occ", 32'(occupancy), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        reset_model();
        step(4'hF, 1'b0);
        check("post_arst_gnt0", 32'(sb[0]), 32'd0);
        step('0, 1'b1);
        step('0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_push_arb.md
# fifo_push_arb

Round-robin push arbiter and occupancy tracker that shares one single-clock FIFO's push port between NREQ producers. It sits directly in front of the team's dual-bank single-port FIFO. It grants at most one producer per cycle and gates pushes on its own occupancy count, so the FIFO never sees a push while full. It records the producer ID of every accepted entry, and on each pop it returns that ID aligned with the FIFO's read data.

## Interface
- NREQ, 4: number of producers, 2..16.
- WIDTH, 16: data width; must match the downstream FIFO.
- SIZE, 32: downstream FIFO depth; power of two, at least 4; must match the FIFO.
- QUOTA, 8: maximum entries one producer may hold in the FIFO, 1..SIZE. Used only when the quota feature is compiled in.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset. Must also reset the downstream FIFO.
- req  in  NREQ  per-producer push request.
- req_data  in  NREQ*WIDTH  producer i's data on bits [i*WIDTH +: WIDTH].
- gnt  out  NREQ  one-hot or zero; combinational; gnt[i]=1 means producer i's word is accepted this cycle.
- fifo_push  out  1  equals |gnt; connects to the FIFO push.
- fifo_wdata  out  WIDTH  the granted producer's data; 0 when there is no grant.
- pop  in  1  consumer pop request.
- fifo_pop  out  1  pop && !empty; connects to the FIFO pop.
- rvalid  out  1  registered; high one cycle after an accepted pop.
- rtag  out  $clog2(NREQ)  registered producer ID of the popped entry; valid when rvalid=1.
- occupancy  out  $clog2(SIZE)+1  registered count of entries in the FIFO.
- full  out  1  occupancy==SIZE.
- empty  out  1  occupancy==0.

## Operation
- State:
  - Round-robin pointer rr, range 0..NREQ-1.
  - occupancy.
  - Tag store: SIZE × $clog2(NREQ), with rd/wr pointers of $clog2(SIZE)+1 bits. The MSB is a wrap bit; the lower bits index the store.
  - Per-producer counters cnt[i], $clog2(SIZE)+1 bits (quota build only).
- Eligibility for producer i: req[i] && !full, plus cnt[i] < QUOTA when the quota feature is compiled in.
  - full and cnt are taken from registered state only. A pop in the same cycle does not free a slot that cycle.
- Arbitration: the first eligible producer scanning rr, rr+1, …, wrapping mod NREQ, receives the grant.
  - On a grant to k: rr <= (k+1) mod NREQ.
  - With no grant, rr is held.
- Push accepted (any gnt):
  - Write the tag store at wr_ptr, then wr_ptr+1.
  - Increment cnt[k].
- Pop accepted (fifo_pop):
  - Read the tag at rd_ptr, then rd_ptr+1.
  - Decrement cnt[tag].
  - rtag <= tag; rvalid <= 1.
- A cycle with no pop sets rvalid <= 0. rtag holds its last value.
- occupancy update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Push and pop for the same producer in one cycle leaves cnt unchanged.
- Pointer wrap: pointers roll from 2*SIZE-1 to 0 naturally. occupancy equals wr_ptr−rd_ptr modulo 2*SIZE.
- A pop while empty is ignored: no pointer change and rvalid=0.
- A push while full is impossible by construction.
- req_data only needs to be valid in the cycle where req is high. A producer may drop req without a grant.

## Timing
- Values after reset:
  - gnt=0, fifo_push=0, fifo_wdata=0, fifo_pop=0 (while pop=0).
  - rvalid=0, rtag=0, occupancy=0, full=0, empty=1.
  - rr=0, all pointers and counters 0.
- gnt, fifo_push, fifo_wdata and fifo_pop are combinational from inputs and registered state, with no added latency.
- Pop to rvalid/rtag is 1 cycle. This matches the FIFO's valid/rdata timing, so rtag pairs with rdata in the same cycle.
- A burst of pops gives back-to-back rvalid with tags in push order.
- rst asserted mid-operation clears all state asynchronously. Any in-flight rvalid is dropped, and outputs take their reset values while rst=1.

## Configuration
- FIFO_PUSH_ARB_QUOTA_EN defined: per-producer cnt[i] and QUOTA gating are built.
- FIFO_PUSH_ARB_QUOTA_EN undefined: cnt is removed and QUOTA is ignored. Eligibility is req[i] && !full. Tag store, rtag and occupancy behave the same in both builds.

## Test plan
- Reset: assert rst for 3 cycles with req=4'hF and pop=1 -> gnt=0, fifo_pop=0, rvalid=0, occupancy=0, empty=1.
- Fairness: NREQ=4, SIZE=32, QUOTA=8, quota build, req=4'hF held with no pop -> grants 0,1,2,3 repeat 8 times. After 32 pushes, full=1, gnt=0, every cnt=8.
- Quota: QUOTA=4, req=4'b0001 held -> 4 grants, then gnt=0 with occupancy=4. One pop frees a slot, and the next cycle grants producer 0 again. The non-quota build gives 32 grants, then full=1.
- Full boundary: occupancy=32 with pop=1 and req=1 in the same cycle -> no grant that cycle, occupancy=31 next. The grant arrives the following cycle and occupancy returns to 32.
- Tag order: single pushes from producers 3, 1, 0, then pop held for 3 cycles -> rvalid high for cycles 1–3 after the first pop, with rtag 3, 1, 0, then rvalid=0.
- Empty pop and wrap: pop while empty -> fifo_pop=0 and rvalid stays 0. Run 100 push/pop pairs so the pointers wrap -> tags stay in order and occupancy never exceeds 32.
